cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Execution controller for the single-cycle CPU that gates every architectural state update through one clock-enable pulse. It conditions the raw BTN2 push-button with a synchronizer and debounce filter, and supports single-step, free-run at a divided rate, and a PC-match breakpoint. It sits between the board inputs (BTN2, SW) and the CPU datapath in `top`. It also exports a step counter for the LCD/LED debug display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to change the debounced button level (≥2)
- RUN_DIV, 8, CCLK cycles per instruction in RUN state (≥2)

Ports:
- CCLK  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- BTN2  in  1  raw step/run push-button, asynchronous to CCLK
- run_sw  in  1  mode select: 0 = single-step, 1 = free-run (board SW[0])
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint instruction address
- PC  in  32  current CPU program counter
- cpu_ce  out  1  CPU clock enable; PC, register file and data memory write only while high
- halted  out  1  high in HALT state
- state  out  2  IDLE=00, STEP=01, RUN=10, HALT=11
- step_count  out  16  number of cpu_ce pulses issued, wraps

## Operation
- Button path: two-flop synchronizer, then debounce counter. Counter increments each cycle the synchronized sample differs from the debounced level. It clears whenever they match. The level flips on the cycle the count would reach DEBOUNCE_CYCLES. A press event is a single cycle, generated on a 0→1 flip only.
- IDLE: cpu_ce=0.
  - Press with run_sw=0 → STEP.
  - Press with run_sw=1 → RUN, divider cleared to 0.
- STEP: cpu_ce=1 for exactly this one cycle → IDLE. The breakpoint never blocks STEP.
- RUN: divider counts 0..RUN_DIV-1 and wraps.
  - At terminal count, cpu_ce=1, unless bp_en=1 and PC==bp_addr. In that case, cpu_ce=0 and the next state is HALT.
  - Press event → IDLE, no cpu_ce that cycle.
  - run_sw=0 → IDLE.
- HALT: cpu_ce=0, halted=1.
  - Press event → STEP, which executes the breakpoint instruction, then → IDLE.
  - run_sw has no effect in HALT.
- Priority within one cycle: rst > press event > run_sw drop > breakpoint > divider terminal.
- step_count increments by 1 on every cycle cpu_ce=1. It wraps 0xFFFF→0x0000.
- Outputs are registered, except `halted` and `state`, which decode directly from the state register.

## Timing
- Reset values, applied asynchronously on rst=1 and held while rst=1:
  - state=IDLE, cpu_ce=0, halted=0, step_count=0
  - synchronizer flops, debounce level, debounce counter and divider all 0
- Reset asserted mid-pulse drops cpu_ce immediately; no partial step is counted.
- Press latency: call edge 1 the first CCLK edge that samples BTN2=1. The debounced level rises at edge DEBOUNCE_CYCLES+2. cpu_ce is high for the one cycle following edge DEBOUNCE_CYCLES+3.
- BTN2 high for fewer than DEBOUNCE_CYCLES consecutive samples produces no event. A bounce on release of the same length produces no second event.
- A held button produces exactly one event. A new event requires a debounced release and then a debounced press.
- RUN: the first cpu_ce fires RUN_DIV cycles after entering RUN. After that, cpu_ce fires every RUN_DIV cycles; pulses are always one cycle wide.
- Breakpoint compare uses the PC value present in the terminal-count cycle. HALT is entered on the following edge.
- cpu_ce is never high on two consecutive cycles (RUN_DIV ≥2).

## Test plan
- Reset then single step: rst pulse, run_sw=0, BTN2 high 5 cycles (DEBOUNCE_CYCLES=4) → exactly one cpu_ce pulse at edge 7, step_count=1, state back to 00.
- Glitch rejection: BTN2 high 3 cycles, then low 10 cycles → no cpu_ce, step_count unchanged.
- Seven button presses spaced 50 cycles apart → 7 cpu_ce pulses, step_count=7, no double counts from holding the button.
- Free-run with RUN_DIV=8: run_sw=1, one press → cpu_ce every 8 cycles. After 10 pulses, press again → IDLE and cpu_ce stops; step_count=10.
- Breakpoint: bp_en=1, bp_addr=0x0000000C, PC driven +4 per cpu_ce from 0 → pulses for PC 0, 4, 8, then HALT with halted=1 and step_count=3. One press → one pulse, then state=IDLE, step_count=4.
- Async reset mid-RUN: assert rst between divider counts → cpu_ce=0, state=00 and step_count=0 before the next CCLK edge. Counting resumes only after a new press.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle CPU: conditions BTN2 and issues one-cycle
// cpu_ce pulses for single-step, divided free-run and PC-match breakpoint halting.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_DIV         = 8
) (
    input  logic        CCLK,
    input  logic        rst,
    input  logic        BTN2,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] PC,
    output logic        cpu_ce,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(RUN_DIV);

    logic             btn_meta;
    logic             btn_sync;
    logic             db_level;
    logic [DB_W-1:0]  db_count;
    logic             press_evt;
    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             ce_d;

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= BTN2;
            btn_sync <= btn_meta;
        end
    end

    // The level flips on the cycle the run of differing samples would reach
    // DEBOUNCE_CYCLES; only a 0->1 flip raises the one-cycle press event.
    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            db_level  <= 1'b0;
            db_count  <= '0;
            press_evt <= 1'b0;
        end else if (btn_sync == db_level) begin
            db_count  <= '0;
            press_evt <= 1'b0;
        end else if (db_count == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level  <= btn_sync;
            db_count  <= '0;
            press_evt <= btn_sync;
        end else begin
            db_count  <= db_count + DB_W'(1);
            press_evt <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_evt) begin
                    if (run_sw) begin
                        state_d = RUN;
                        div_d   = '0;
                    end else begin
                        state_d = STEP;
                        ce_d    = 1'b1;
                    end
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                if (press_evt || !run_sw) begin
                    state_d = IDLE;
                end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
                    div_d = '0;
                    if (bp_en && (PC == bp_addr)) begin
                        state_d = HALT;
                    end else begin
                        ce_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HALT: begin
                // Stepping out of HALT executes the breakpoint instruction itself.
                if (press_evt) begin
                    state_d = STEP;
                    ce_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CCLK or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cpu_ce     <= 1'b0;
            step_count <= 16'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cpu_ce  <= ce_d;
            if (cpu_ce) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    assign state  = state_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: a sample-window/phase model predicts every output each cycle,
// while directed scenarios pin step, glitch, run, breakpoint and async reset behaviour.
module tb_cpu_step_ctrl;

    localparam int DC  = 4;
    localparam int DIV = 8;

    logic        CCLK;
    logic        rst;
    logic        BTN2;
    logic        run_sw;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] PC;
    logic        cpu_ce;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] step_count;

    int pass_count = 0;
    int check_count = 0;

    bit pc_clear = 1'b0;
    bit pc_track = 1'b0;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DC), .RUN_DIV(DIV)) dut (
        .CCLK(CCLK),
        .rst(rst),
        .BTN2(BTN2),
        .run_sw(run_sw),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .PC(PC),
        .cpu_ce(cpu_ce),
        .halted(halted),
        .state(state),
        .step_count(step_count)
    );

    initial begin
        CCLK = 1'b0;
        forever #5 CCLK = ~CCLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic btn, input logic sw, input int cycles);
        @(negedge CCLK);
        BTN2   = btn;
        run_sw = sw;
        repeat (cycles) @(posedge CCLK);
    endtask

    // Model: the button level toggles once the DC synchronized samples ending two edges
    // ago all disagree with it; RUN fires on every DIV-th cycle counted from entry.
    bit        hist[$];
    bit        m_level;
    bit        m_rise;
    bit        m_press;
    bit        m_all_diff;
    bit        m_ce;
    bit        m_ce_next;
    logic [1:0]  m_state;
    logic [1:0]  m_next;
    int        m_phase;
    logic [15:0] m_count;

    always @(posedge CCLK or posedge rst) begin
        if (rst) begin
            hist = {};
            for (int i = 0; i < DC + 2; i++) hist.push_back(1'b0);
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_state = 2'b00;
            m_phase = 0;
            m_ce    = 1'b0;
            m_count = 16'd0;
        end else begin
            if (pc_clear) PC <= 32'd0;
            else if (pc_track && m_ce) PC <= PC + 32'd4;

            m_press = m_rise;
            hist.push_back(BTN2);
            void'(hist.pop_front());
            m_all_diff = 1'b1;
            for (int i = 0; i < DC; i++)
                if (hist[i] == m_level) m_all_diff = 1'b0;
            m_rise = m_all_diff && !m_level;
            if (m_all_diff) m_level = !m_level;

            m_next    = m_state;
            m_ce_next = 1'b0;
            case (m_state)
                2'b00: if (m_press) begin
                    if (run_sw) begin m_next = 2'b10; m_phase = 0; end
                    else begin m_next = 2'b01; m_ce_next = 1'b1; end
                end
                2'b01: m_next = 2'b00;
                2'b10: begin
                    if (m_press || !run_sw) m_next = 2'b00;
                    else begin
                        if (m_phase % DIV == DIV - 1) begin
                            if (bp_en && PC == bp_addr) m_next = 2'b11;
                            else m_ce_next = 1'b1;
                        end
                        m_phase = m_phase + 1;
                    end
                end
                default: if (m_press) begin m_next = 2'b01; m_ce_next = 1'b1; end
            endcase
            m_count = m_count + 16'(m_ce);
            m_ce    = m_ce_next;
            m_state = m_next;
        end
    end

    always @(posedge CCLK) begin
        #1;
        if (!rst) begin
            checkOutput("cyc_cpu_ce", 32'(cpu_ce), 32'(m_ce));
            checkOutput("cyc_state", 32'(state), 32'(m_state));
            checkOutput("cyc_halted", 32'(halted), 32'(m_state == 2'b11));
            checkOutput("cyc_step_count", 32'(step_count), 32'(m_count));
        end
    end

    int first_edge;
    int second_edge;
    int edge_no;

    initial begin
        rst = 1'b1; BTN2 = 1'b0; run_sw = 1'b0; bp_en = 1'b0; bp_addr = 32'd0;
        PC = 32'd0;
        repeat (3) @(posedge CCLK);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_cpu_ce", 32'(cpu_ce), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_step_count", 32'(step_count), 32'd0);
        @(negedge CCLK);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5);

        // Single step: pulse expected exactly after edge 7
        @(negedge CCLK);
        BTN2 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge CCLK);
            #1;
            if (e == 6) checkOutput("step_edge6_ce", 32'(cpu_ce), 32'd0);
            if (e == 7) begin
                checkOutput("step_edge7_ce", 32'(cpu_ce), 32'd1);
                checkOutput("step_edge7_state", 32'(state), 32'd1);
            end
            if (e == 8) begin
                checkOutput("step_edge8_ce", 32'(cpu_ce), 32'd0);
                checkOutput("step_edge8_state", 32'(state), 32'd0);
            end
            if (e == 9) checkOutput("step_count_1", 32'(step_count), 32'd1);
            if (e == 5) begin
                @(negedge CCLK);
                BTN2 = 1'b0;
            end
        end

        // Glitch of DC-1 samples
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("glitch_count", 32'(step_count), 32'd1);

        // Seven presses, one with a release bounce
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                applyStimulus(1'b1, 1'b0, 10);
                applyStimulus(1'b0, 1'b0, 2);
                applyStimulus(1'b1, 1'b0, 3);
                applyStimulus(1'b0, 1'b0, 35);
            end else begin
                applyStimulus(1'b1, 1'b0, 10);
                applyStimulus(1'b0, 1'b0, 40);
            end
        end
        checkOutput("seven_presses_count", 32'(step_count), 32'd8);

        // Free-run: 10 pulses, then press stops it on a terminal-count cycle
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 5);
        first_edge = -1; second_edge = -1; edge_no = 0;
        for (int c = 0; c < 200 && m_count != 16'd18; c++) begin
            @(posedge CCLK);
            #1;
            edge_no++;
            if (cpu_ce) begin
                if (first_edge < 0) first_edge = edge_no;
                else if (second_edge < 0) second_edge = edge_no;
            end
        end
        checkOutput("run_ten_pulses", 32'(m_count), 32'd18);
        checkOutput("run_period", 32'(second_edge - first_edge), 32'(DIV));
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 30);
        checkOutput("run_stop_state", 32'(state), 32'd0);
        checkOutput("run_stop_count", 32'(step_count), 32'd18);

        // run_sw drop lands on a terminal-count cycle
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("swdrop_state", 32'(state), 32'd0);
        checkOutput("swdrop_count", 32'(step_count), 32'd20);

        // Breakpoint at 0xC
        @(negedge CCLK);
        pc_clear = 1'b1;
        @(negedge CCLK);
        pc_clear = 1'b0; pc_track = 1'b1; bp_en = 1'b1; bp_addr = 32'h0000000C;
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        for (int c = 0; c < 100 && m_state != 2'b11; c++) @(posedge CCLK);
        applyStimulus(1'b0, 1'b1, 10);
        #1;
        checkOutput("bp_halted", 32'(halted), 32'd1);
        checkOutput("bp_state", 32'(state), 32'd3);
        checkOutput("bp_count", 32'(step_count), 32'd23);
        checkOutput("bp_pc", PC, 32'd12);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 20);
        #1;
        checkOutput("bp_step_state", 32'(state), 32'd0);
        checkOutput("bp_step_halted", 32'(halted), 32'd0);
        checkOutput("bp_step_count", 32'(step_count), 32'd24);
        checkOutput("bp_step_pc", PC, 32'd16);
        @(negedge CCLK);
        bp_en = 1'b0; pc_track = 1'b0;

        // Async reset during a RUN pulse
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 5);
        for (int c = 0; c < 100 && !m_ce; c++) begin
            @(posedge CCLK);
            #1;
        end
        checkOutput("pre_reset_ce", 32'(cpu_ce), 32'd1);
        @(negedge CCLK);
        rst = 1'b1;
        #1;
        checkOutput("areset_ce", 32'(cpu_ce), 32'd0);
        checkOutput("areset_state", 32'(state), 32'd0);
        checkOutput("areset_count", 32'(step_count), 32'd0);
        repeat (3) @(posedge CCLK);
        @(negedge CCLK);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 30);
        checkOutput("post_reset_count", 32'(step_count), 32'd0);
        checkOutput("post_reset_state", 32'(state), 32'd0);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        #1;
        checkOutput("rerun_state", 32'(state), 32'd2);
        applyStimulus(1'b0, 1'b0, 5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
